// File: rtl/modulo_count_sequencer_pkg.sv
// Shared definitions for the modulo count sequencer: default sizing and FSM state encoding.
package modulo_count_sequencer_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 3;
  localparam int unsigned TERM_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/modulo_count_sequencer_core.sv
// Count register with terminal compare and a phase flop that flips on every wrap.
module modulo_count_sequencer_core
  import modulo_count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             phase_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  assign tc_o    = en_i && (count_q == term_i);
  assign count_o = count_q;
  assign phase_o = phase_q;

  // Wrap to zero at the terminal value; otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (tc_o) begin
      count_d = '0;
      phase_d = ~phase_q;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/modulo_count_sequencer.sv
// Run/stop sequencer for a programmable modulo counter with a shadowed terminal-value handshake.
module modulo_count_sequencer
  import modulo_count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = CNT_WIDTH_DEF,
  parameter int unsigned DEFAULT_TERM = TERM_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_valid_i,
  input  logic [WIDTH-1:0] cfg_term_i,
  output logic             cfg_ready_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             phase_o,
  output logic             busy_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_v_q, shadow_v_d;
  logic             busy;
  logic             tc;
  logic             accept;

  assign busy        = (state_q != ST_IDLE);
  assign cfg_ready_o = !busy || !shadow_v_q;
  assign accept      = cfg_valid_i && cfg_ready_o;
  assign busy_o      = busy;
  assign tc_o        = tc;

  modulo_count_sequencer_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i   (clk_i),
    .clr_i   (reset_i),
    .en_i    (busy),
    .term_i  (term_q),
    .count_o (count_o),
    .tc_o    (tc),
    .phase_o (phase_o)
  );

  // Next state plus terminal/shadow update; term only moves in IDLE or on a wrap edge.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    shadow_d   = shadow_q;
    shadow_v_d = shadow_v_q;

    case (state_q)
      ST_IDLE:     if (start_i && !stop_i) state_d = ST_RUN;
      ST_RUN:      if (stop_i) state_d = tc ? ST_IDLE : ST_STOPPING;
      ST_STOPPING: begin
        if (start_i && !stop_i) state_d = ST_RUN;
        else if (tc)            state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase

    if (!busy) begin
      if (accept) term_d = cfg_term_i;
    end else if (state_d == ST_IDLE) begin
      // Final wrap: anything pending lands directly in term_q.
      shadow_v_d = 1'b0;
      if (accept)          term_d = cfg_term_i;
      else if (shadow_v_q) term_d = shadow_q;
    end else begin
      if (tc && shadow_v_q) begin
        term_d     = shadow_q;
        shadow_v_d = 1'b0;
      end
      if (accept) begin
        shadow_d   = cfg_term_i;
        shadow_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      term_q     <= WIDTH'(DEFAULT_TERM);
      shadow_q   <= '0;
      shadow_v_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      shadow_q   <= shadow_d;
      shadow_v_q <= shadow_v_d;
    end
  end

endmodule

// File: tb/tb_modulo_count_sequencer.sv
// Scoreboard bench: a behavioural model predicts post-edge outputs, a monitor compares them.
module tb_modulo_count_sequencer;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         cfg_valid_i = 1'b0;
  logic [W-1:0] cfg_term_i = '0;
  logic         cfg_ready_o;
  logic [W-1:0] count_o;
  logic         tc_o;
  logic         phase_o;
  logic         busy_o;

  always #5 clk = ~clk;

  modulo_count_sequencer #(.WIDTH(W), .DEFAULT_TERM(5)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_term_i  (cfg_term_i),
    .cfg_ready_o (cfg_ready_o),
    .count_o     (count_o),
    .tc_o        (tc_o),
    .phase_o     (phase_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int count;
    bit tc;
    bit phase;
    bit busy;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: running flag, pending-stop flag, integer count/term, pending term (-1 = none).
  bit m_run, m_stopreq, m_phase;
  int m_count, m_term, m_pend;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit sp, input bit cv, input int ct);
    bit   tc, ready, accept;
    exp_t e;
    if (rst) begin
      m_run = 0; m_stopreq = 0; m_phase = 0;
      m_count = 0; m_term = 5; m_pend = -1;
    end else begin
      tc     = m_run && (m_count == m_term);
      ready  = !m_run || (m_pend < 0);
      accept = cv && ready;
      if (!m_run) begin
        if (accept) m_term = ct;
        if (st && !sp) begin
          m_run = 1;
          m_stopreq = 0;
        end
      end else begin
        if (tc) begin
          m_count = 0;
          m_phase = !m_phase;
        end else begin
          m_count = m_count + 1;
        end
        if (sp) begin
          if (tc) m_run = 0;
          else    m_stopreq = 1;
        end else if (st && m_stopreq) begin
          m_stopreq = 0;
        end else if (m_stopreq && tc) begin
          m_run = 0;
        end
        if (!m_run) begin
          if (accept)          m_term = ct;
          else if (m_pend >= 0) m_term = m_pend;
          m_pend = -1;
          m_stopreq = 0;
        end else begin
          if (tc && m_pend >= 0) begin
            m_term = m_pend;
            m_pend = -1;
          end
          if (accept) m_pend = ct;
        end
      end
    end
    e.count = m_count;
    e.tc    = m_run && (m_count == m_term);
    e.phase = m_phase;
    e.busy  = m_run;
    e.ready = !m_run || (m_pend < 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit st, input bit sp, input bit cv, input int ct);
    @(negedge clk);
    reset_i     = rst;
    start_i     = st;
    stop_i      = sp;
    cfg_valid_i = cv;
    cfg_term_i  = W'(ct);
    model_step(rst, st, sp, cv, ct);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic run_to_count(input int c);
    for (int i = 0; i < 20 && !(m_run && m_count == c); i++) drive(0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one prediction per clock edge and compares every output.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count",     int'(count_o),     e.count);
      chk("tc",        int'(tc_o),        int'(e.tc));
      chk("phase",     int'(phase_o),     int'(e.phase));
      chk("busy",      int'(busy_o),      int'(e.busy));
      chk("cfg_ready", int'(cfg_ready_o), int'(e.ready));
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Basic run with default term, two wraps.
    drive(0, 1, 0, 0, 0);
    idle(13);

    // Stop mid-period, then stop exactly at the terminal count.
    run_to_count(2);
    drive(0, 0, 1, 0, 0);
    idle(6);
    drive(0, 1, 0, 0, 0);
    run_to_count(5);
    drive(0, 0, 1, 0, 0);
    idle(3);

    // Shadowed reconfiguration while running.
    drive(0, 1, 0, 0, 0);
    run_to_count(1);
    drive(0, 0, 0, 1, 2);
    drive(0, 0, 0, 1, 4);
    idle(9);
    drive(0, 0, 1, 0, 0);
    idle(6);

    // Term zero loaded together with start.
    drive(0, 1, 0, 1, 0);
    idle(5);
    drive(0, 0, 1, 0, 0);
    idle(2);

    // start&stop in IDLE, then start cancels a pending stop.
    drive(0, 1, 1, 1, 5);
    idle(2);
    drive(0, 1, 0, 0, 0);
    run_to_count(1);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    idle(10);
    drive(0, 0, 1, 1, 7);
    idle(10);

    // Full-range term, then reset with a shadow pending.
    drive(0, 1, 0, 0, 0);
    idle(10);
    drive(0, 0, 0, 1, 3);
    run_to_count(3);
    drive(1, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
